// File: rtl/seg_accum_recombine_pkg.sv
// Shared types and derived widths for the KO4 segment recombination stage.
package seg_accum_recombine_pkg;

    localparam int unsigned DATA_WIDTH   = 72;
    localparam int unsigned KO_PARAMETER = 4;

    localparam int unsigned SEG_W     = DATA_WIDTH / KO_PARAMETER;
    localparam int unsigned SEG_RES_W = SEG_W + 3;
    localparam int unsigned NUM_SEG   = 2 * KO_PARAMETER - 1;
    localparam int unsigned PROD_W    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccum   = 2'd1,
        StDone    = 2'd2,
        StResolve = 2'd3
    } state_e;

    // Place a segment sum at its column weight 2^(SEG_W*idx) inside a product-wide word.
    function automatic logic [PROD_W-1:0] seg_weighted(input logic [SEG_RES_W-1:0] seg,
                                                       input logic [CNT_W-1:0]     idx);
        logic [PROD_W-1:0] ext;
        ext = {{(PROD_W - SEG_RES_W){1'b0}}, seg};
        return ext << (SEG_W * 32'(idx));
    endfunction

endpackage

// File: rtl/seg_accum_recombine_if.sv
// Handshake bundle of the segment recombination stage: segment input, product output,
// flush and progress counter. master = producer/consumer side, slave = the stage.
interface seg_accum_recombine_if;
    import seg_accum_recombine_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [SEG_RES_W-1:0] in_seg;
    logic                 out_valid;
    logic                 out_ready;
    logic [PROD_W-1:0]    out_product;
    logic [CNT_W-1:0]     seg_cnt;

    modport master (
        output flush, in_valid, in_seg, out_ready,
        input  in_ready, out_valid, out_product, seg_cnt
    );

    modport slave (
        input  flush, in_valid, in_seg, out_ready,
        output in_ready, out_valid, out_product, seg_cnt
    );

endinterface

// File: rtl/seg_accum_recombine_csa_row.sv
// One product-wide row of 3:2 compressors. The carry vector comes out already shifted to
// its column weight; the carry out of the top column is dropped (arithmetic mod 2^Width).
module seg_accum_recombine_csa_row #(
    parameter int unsigned Width = 144
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [Width-1:0] c,
    output logic [Width-1:0] sum,
    output logic [Width-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[Width-2:0] & b[Width-2:0]) |
                    (a[Width-2:0] & c[Width-2:0]) |
                    (b[Width-2:0] & c[Width-2:0]), 1'b0};

endmodule

// File: rtl/seg_accum_recombine.sv
// Sequential recombination of the seven KO4 column-segment sums into a 144-bit product.
// Segments arrive in ascending column order; each is weighted by 2^(SEG_W*k) and summed.
// Build option SEG_ACCUM_CARRY_SAVE_EN: keep the accumulator in carry-save form and resolve
// it in an extra cycle (latency 2 instead of 1); products are identical in both builds.
module seg_accum_recombine
    import seg_accum_recombine_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    seg_accum_recombine_if.slave bus
);

    state_e               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [PROD_W-1:0]    out_product_q;
    logic [CNT_W-1:0]     seg_cnt_q;

    logic                 accept;
    logic                 last_seg;
    logic [PROD_W-1:0]    weighted;

    assign accept   = bus.in_valid & in_ready_q;
    assign last_seg = (seg_cnt_q == CNT_W'(NUM_SEG - 1));
    assign weighted = seg_weighted(bus.in_seg, seg_cnt_q);

`ifdef SEG_ACCUM_CARRY_SAVE_EN
    logic [PROD_W-1:0] sum_q;
    logic [PROD_W-1:0] carry_q;
    logic [PROD_W-1:0] row_sum;
    logic [PROD_W-1:0] row_carry;

    seg_accum_recombine_csa_row #(
        .Width (PROD_W)
    ) u_csa_row (
        .a     (sum_q),
        .b     (carry_q),
        .c     (weighted),
        .sum   (row_sum),
        .carry (row_carry)
    );
`else
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] acc_next;

    assign acc_next = acc_q + weighted;
`endif

    // Control FSM with registered handshake outputs and the accumulator datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            seg_cnt_q     <= '0;
`ifdef SEG_ACCUM_CARRY_SAVE_EN
            sum_q         <= '0;
            carry_q       <= '0;
`else
            acc_q         <= '0;
`endif
        end else if (bus.flush) begin
            // Abort wins over any concurrent input accept or output handshake.
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            seg_cnt_q   <= '0;
`ifdef SEG_ACCUM_CARRY_SAVE_EN
            sum_q       <= '0;
            carry_q     <= '0;
`else
            acc_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
`ifdef SEG_ACCUM_CARRY_SAVE_EN
                        sum_q   <= row_sum;
                        carry_q <= row_carry;
`else
                        acc_q   <= acc_next;
`endif
                        if (last_seg) begin
                            seg_cnt_q  <= '0;
                            in_ready_q <= 1'b0;
`ifdef SEG_ACCUM_CARRY_SAVE_EN
                            state_q    <= StResolve;
`else
                            state_q       <= StDone;
                            out_valid_q   <= 1'b1;
                            out_product_q <= acc_next;
`endif
                        end else begin
                            seg_cnt_q <= seg_cnt_q + CNT_W'(1);
                            state_q   <= StAccum;
                        end
                    end
                end
`ifdef SEG_ACCUM_CARRY_SAVE_EN
                StResolve: begin
                    // Carry-propagate add of the redundant accumulator.
                    out_product_q <= sum_q + carry_q;
                    out_valid_q   <= 1'b1;
                    state_q       <= StDone;
                end
`endif
                StDone: begin
                    // Product held until consumed; out_product keeps its last value after.
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef SEG_ACCUM_CARRY_SAVE_EN
                        sum_q       <= '0;
                        carry_q     <= '0;
`else
                        acc_q       <= '0;
`endif
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    seg_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.seg_cnt     = seg_cnt_q;

endmodule

// File: tb/tb_seg_accum_recombine.sv
// Randomised self-checking bench for seg_accum_recombine against a Horner-form product model.
module tb_seg_accum_recombine;
    import seg_accum_recombine_pkg::*;

`ifdef SEG_ACCUM_CARRY_SAVE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [SEG_RES_W-1:0] segs [NUM_SEG];

    seg_accum_recombine_if bus ();

    seg_accum_recombine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [PROD_W-1:0] obs,
                            input logic [PROD_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    // Product = sum_k segs[k] * 2^(18k), evaluated by Horner's rule, mod 2^PROD_W.
    function automatic logic [PROD_W-1:0] ref_product();
        logic [PROD_W-1:0] p = '0;
        for (int k = NUM_SEG - 1; k >= 0; k--) begin
            p = p * (2 ** SEG_W) + PROD_W'(segs[k]);
        end
        return p;
    endfunction

    task automatic send_seg(input logic [SEG_RES_W-1:0] seg);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_seg   = seg;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", PROD_W'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_product(input int gap_max);
        for (int k = 0; k < NUM_SEG; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_seg(segs[k]);
            check_eq("seg_cnt_step", PROD_W'(bus.seg_cnt),
                     PROD_W'((k == NUM_SEG - 1) ? 0 : k + 1));
        end
    endtask

    // Called #1 after the last accepting edge.
    task automatic collect_product(input string tag, input logic [PROD_W-1:0] exp,
                                   input int bp);
        int cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_valid && cycles < 20);
        check_eq({tag, "_latency"}, PROD_W'(cycles), PROD_W'(Lat));
        check_eq({tag, "_product"}, bus.out_product, exp);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, PROD_W'(bus.out_valid), 1);
            check_eq({tag, "_hold_ready"}, PROD_W'(bus.in_ready), 0);
            check_eq({tag, "_hold_product"}, bus.out_product, exp);
        end
        bus.out_ready = 1'b1;
        check_eq({tag, "_ready_at_hs"}, PROD_W'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_valid_after_hs"}, PROD_W'(bus.out_valid), 0);
        check_eq({tag, "_ready_after_hs"}, PROD_W'(bus.in_ready), 1);
        check_eq({tag, "_product_kept"}, bus.out_product, exp);
    endtask

    task automatic fill_random();
        int unsigned mode = $urandom_range(0, 3);
        for (int k = 0; k < NUM_SEG; k++) begin
            if (mode == 0) segs[k] = '1;
            else if (mode == 1) segs[k] = ($urandom_range(0, 1) == 1) ?
                                          SEG_RES_W'($urandom_range(0, 32'h1FFFFF)) : '0;
            else segs[k] = SEG_RES_W'($urandom_range(0, 32'h1FFFFF));
        end
    endtask

    initial begin
        logic [PROD_W-1:0] exp;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_seg    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", PROD_W'(bus.in_ready), 0);
        check_eq("rst_out_valid", PROD_W'(bus.out_valid), 0);
        check_eq("rst_seg_cnt", PROD_W'(bus.seg_cnt), 0);
        check_eq("rst_out_product", bus.out_product, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", PROD_W'(bus.in_ready), 1);

        // Directed: low segment only
        foreach (segs[k]) segs[k] = '0;
        segs[0] = 21'd5;
        send_product(0);
        collect_product("t1", 144'd5, 0);

        // Directed: top segment only
        foreach (segs[k]) segs[k] = '0;
        segs[6] = 21'd1;
        send_product(0);
        exp = 144'd1 << 108;
        collect_product("t2", exp, 0);

        // Directed: all ones, golden from model
        foreach (segs[k]) segs[k] = 21'h1FFFFF;
        send_product(1);
        collect_product("t2_ones", ref_product(), 1);

        // Directed: cross-segment carry
        foreach (segs[k]) segs[k] = '0;
        segs[0] = 21'h1FFFFF;
        segs[1] = 21'h1FFFFF;
        send_product(0);
        collect_product("t3", 144'h80_001B_FFFF, 0);

        // Backpressure for five cycles, then next product
        fill_random();
        send_product(0);
        collect_product("t4_bp", ref_product(), 5);
        fill_random();
        send_product(0);
        collect_product("t4_next", ref_product(), 0);

        // Flush with a concurrent accept at seg_cnt=3
        fill_random();
        for (int k = 0; k < 3; k++) send_seg(segs[k]);
        check_eq("t5_cnt_before", PROD_W'(bus.seg_cnt), 3);
        bus.in_valid = 1'b1;
        bus.in_seg   = 21'h1ABCDE;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("t5_cnt_after", PROD_W'(bus.seg_cnt), 0);
        fill_random();
        send_product(0);
        collect_product("t5_fresh", ref_product(), 0);

        // Flush against a pending output handshake
        fill_random();
        send_product(0);
        repeat (Lat) @(negedge clk);
        check_eq("t5d_valid", PROD_W'(bus.out_valid), 1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("t5d_valid_after", PROD_W'(bus.out_valid), 0);
        check_eq("t5d_ready_after", PROD_W'(bus.in_ready), 1);
        fill_random();
        send_product(0);
        collect_product("t5d_next", ref_product(), 0);

        // Asynchronous reset mid-accumulation
        fill_random();
        for (int k = 0; k < 4; k++) send_seg(segs[k]);
        check_eq("t6_cnt_before", PROD_W'(bus.seg_cnt), 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_out_valid", PROD_W'(bus.out_valid), 0);
        check_eq("t6_seg_cnt", PROD_W'(bus.seg_cnt), 0);
        check_eq("t6_in_ready", PROD_W'(bus.in_ready), 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        fill_random();
        send_product(0);
        collect_product("t6_fresh", ref_product(), 0);

        // Randomised products with gaps and backpressure
        for (int n = 0; n < 25; n++) begin
            fill_random();
            send_product(2);
            collect_product("rand", ref_product(), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
